// File: rtl/ele_ctrl_nfloor.sv
// ele_ctrl_nfloor: N-floor SCAN elevator controller.
// Latches hall/car key presses, serves them in SCAN order, and times travel
// and door phases from a shared 100 ms prescaler.
// Optional build macro ELE_DOOR_HOLD_EN adds the door_hold input.
module ele_ctrl_nfloor #(
    parameter int FLOORS   = 4,
    parameter int TICK_DIV = 5000000,
    parameter int TRAVEL_T = 20,
    parameter int DOOR_T   = 30,
    parameter int BEEP_T   = 2
) (
    input  logic                                             clk,
    input  logic                                             sysclr_n,
    input  logic                                             en,
`ifdef ELE_DOOR_HOLD_EN
    input  logic                                             door_hold,
`endif
    input  logic [FLOORS-1:0]                                key,
    output logic [FLOORS-1:0]                                led,
    output logic [((FLOORS > 1) ? $clog2(FLOORS) : 1)-1:0]   floor_disp,
    output logic                                             state_up,
    output logic                                             state_down,
    output logic                                             state_stay,
    output logic                                             door_open,
    output logic                                             beep_en,
    output logic [3:0]                                       cnt_s_disp,
    output logic [3:0]                                       cnt_ms_disp
);

    localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [6:0]    TRAVEL_LD = 7'(TRAVEL_T);
    localparam logic [6:0]    DOOR_LD   = 7'(DOOR_T);
    localparam logic [6:0]    BEEP_LIM  = 7'(BEEP_T);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic              dir_q, dir_d;          // 1 = up
    logic [FLOORS-1:0] req_q, req_d;
    logic [FLOORS-1:0] key_q;
    logic [6:0]        timer_q, timer_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [6:0]        beep_q, beep_d;        // ticks elapsed in the current door phase

    logic              up_q, down_q, stay_q, door_q, buzz_q;
    logic [3:0]        dig_s_q, dig_ms_q;

    logic [FLOORS-1:0] press;
    logic              active, tick, up_pend, dn_pend, own_press;
    logic [FW-1:0]     nf;

    // Next-state: key edges, request latch, prescaler, phase timer and SCAN decisions
    always_comb begin
        press     = key & ~key_q;
        active    = (state_q != S_IDLE);
        tick      = en && active && (presc_q == PRESC_MAX);
        nf        = (state_q == S_MOVE_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
        own_press = en && press[floor_q] && (state_q == S_IDLE || state_q == S_DOOR);

        up_pend = 1'b0;
        dn_pend = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (req_q[i] && (i > 32'(floor_q))) up_pend = 1'b1;
            if (req_q[i] && (i < 32'(floor_q))) dn_pend = 1'b1;
        end

        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        beep_d  = beep_q;
        presc_d = (en && active) ? (tick ? '0 : presc_q + 1'b1) : presc_q;
        req_d   = req_q | press;
        if (own_press) req_d[floor_q] = req_q[floor_q];

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    // A request for the current floor (latched while frozen) opens the door
                    if (req_q[floor_q]) begin
                        req_d[floor_q] = 1'b0;
                        state_d = S_DOOR;
                        timer_d = DOOR_LD;
                        presc_d = '0;
                        beep_d  = '0;
                    end else if (up_pend && (dir_q || !dn_pend)) begin
                        state_d = S_MOVE_UP;
                        dir_d   = 1'b1;
                        timer_d = TRAVEL_LD;
                        presc_d = '0;
                    end else if (dn_pend) begin
                        state_d = S_MOVE_DOWN;
                        dir_d   = 1'b0;
                        timer_d = TRAVEL_LD;
                        presc_d = '0;
                    end
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (tick) begin
                    if (timer_q <= 7'd1) begin
                        floor_d = nf;
                        dir_d   = (state_q == S_MOVE_UP);
                        if (req_q[nf] || press[nf]) begin
                            req_d[nf] = 1'b0;
                            state_d   = S_DOOR;
                            timer_d   = DOOR_LD;
                            beep_d    = '0;
                        end else begin
                            timer_d = TRAVEL_LD;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            S_DOOR: begin
                if (tick) begin
                    if (beep_q < BEEP_LIM) beep_d = beep_q + 1'b1;
`ifdef ELE_DOOR_HOLD_EN
                    if (door_hold) timer_d = DOOR_LD; else
`endif
                    if (timer_q <= 7'd1) begin
                        if (dir_q ? up_pend : dn_pend) begin
                            state_d = dir_q ? S_MOVE_UP : S_MOVE_DOWN;
                            timer_d = TRAVEL_LD;
                        end else if (dir_q ? dn_pend : up_pend) begin
                            state_d = dir_q ? S_MOVE_DOWN : S_MOVE_UP;
                            dir_d   = !dir_q;
                            timer_d = TRAVEL_LD;
                        end else begin
                            state_d = S_IDLE;
                            timer_d = '0;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pressing the key of the floor we stand at (re)opens the door and restarts the beep
        if (own_press) begin
            state_d = S_DOOR;
            timer_d = DOOR_LD;
            presc_d = '0;
            beep_d  = '0;
        end
    end

    // State, request and timer registers; outputs registered from next-state values
    always_ff @(posedge clk or negedge sysclr_n) begin
        if (!sysclr_n) begin
            state_q  <= S_IDLE;
            floor_q  <= '0;
            dir_q    <= 1'b1;
            req_q    <= '0;
            key_q    <= '0;
            timer_q  <= '0;
            presc_q  <= '0;
            beep_q   <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            stay_q   <= 1'b1;
            door_q   <= 1'b0;
            buzz_q   <= 1'b0;
            dig_s_q  <= '0;
            dig_ms_q <= '0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            req_q    <= req_d;
            key_q    <= key;
            timer_q  <= timer_d;
            presc_q  <= presc_d;
            beep_q   <= beep_d;
            up_q     <= (state_d == S_MOVE_UP);
            down_q   <= (state_d == S_MOVE_DOWN);
            stay_q   <= !(state_d == S_MOVE_UP || state_d == S_MOVE_DOWN);
            door_q   <= (state_d == S_DOOR);
            buzz_q   <= (state_d == S_DOOR) && (beep_d < BEEP_LIM);
            dig_s_q  <= (state_d == S_IDLE) ? 4'd0 : 4'(timer_d / 7'd10);
            dig_ms_q <= (state_d == S_IDLE) ? 4'd0 : 4'(timer_d % 7'd10);
        end
    end

    assign led         = req_q;
    assign floor_disp  = floor_q;
    assign state_up    = up_q;
    assign state_down  = down_q;
    assign state_stay  = stay_q;
    assign door_open   = door_q;
    assign beep_en     = buzz_q;
    assign cnt_s_disp  = dig_s_q;
    assign cnt_ms_disp = dig_ms_q;

endmodule
